// File: rtl/noise_cdf_loader.sv
// ---------------------------------------------------------------------------
// noise_cdf_loader
//   Accepts a DEPTH-entry PMF table over a valid/ready stream, accumulates it
//   into a saturating CDF and writes the CDF into the noise generator's table
//   through load_mem/location/mem_data. After the last word one extra strobe
//   is reissued (the generator commits writes with a one-cycle lag). The
//   loader then waits for done_wait_in, or flags a timeout.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   start                single-cycle pulse, begins a load when not busy
//   pdf_valid/pdf_ready  PMF stream handshake
//   pdf_data             PMF word, unsigned, full scale 2^DATA_W
//   load_mem             table write strobe to the generator
//   location             table index of the current strobe
//   mem_data             CDF value for location
//   done_wait_in         generator reports its table complete
//   busy                 load in progress
//   done                 level-high after a successful load, until next start
//   overflow             sticky, cumulative sum saturated during this load
//   timeout_err          sticky, done_wait_in not seen within TIMEOUT cycles
// ---------------------------------------------------------------------------
module noise_cdf_loader #(
   parameter int unsigned DEPTH   = 128,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              pdf_valid,
   output logic              pdf_ready,
   input  logic [DATA_W-1:0] pdf_data,
   output logic              load_mem,
   output logic [ADDR_W-1:0] location,
   output logic [DATA_W-1:0] mem_data,
   input  logic              done_wait_in,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              timeout_err
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_FLUSH,
      S_WAIT_DONE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t state;
   state_t state_nx;

   // datapath registers
   logic [DATA_W-1:0] acc;
   logic [IDX_W-1:0]  idx;
   logic [CNT_W-1:0]  cnt;

   // next values of all registered state and outputs
   logic [DATA_W-1:0] acc_d;
   logic [IDX_W-1:0]  idx_d;
   logic [CNT_W-1:0]  cnt_d;
   logic              pdf_ready_d;
   logic              load_mem_d;
   logic [ADDR_W-1:0] location_d;
   logic [DATA_W-1:0] mem_data_d;
   logic              busy_d;
   logic              done_d;
   logic              overflow_d;
   logic              timeout_err_d;

   // handshake and saturating accumulate
   logic              accept_c;
   logic [DATA_W:0]   sum_c;
   logic              carry_c;
   logic [DATA_W-1:0] sat_c;
   logic              last_c;
   logic              enter_accum_c;

   assign accept_c      = (state == S_ACCUM) && pdf_valid && pdf_ready;
   assign sum_c         = {1'b0, acc} + {1'b0, pdf_data};
   assign carry_c       = sum_c[DATA_W];
   assign sat_c         = carry_c ? ALL_ONES : sum_c[DATA_W-1:0];
   assign last_c        = (idx == LAST_IDX);
   assign enter_accum_c = (state != S_ACCUM) && (state_nx == S_ACCUM);

   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_nx = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (accept_c && last_c) begin
               state_nx = S_FLUSH;
            end
         end
         S_FLUSH: begin
            state_nx = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            // done_wait_in wins over a coincident timeout
            if (done_wait_in) begin
               state_nx = S_DONE;
            end else if (cnt == CNT_LAST) begin
               state_nx = S_ERROR;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // output / datapath next-value logic
   always_comb begin
      acc_d         = acc;
      idx_d         = idx;
      cnt_d         = '0;
      load_mem_d    = 1'b0;
      location_d    = location;
      mem_data_d    = mem_data;
      done_d        = done;
      overflow_d    = overflow;
      timeout_err_d = timeout_err;
      pdf_ready_d   = (state_nx == S_ACCUM);
      busy_d        = (state_nx == S_ACCUM) || (state_nx == S_FLUSH) ||
                      (state_nx == S_WAIT_DONE);

      if (enter_accum_c) begin
         acc_d         = '0;
         idx_d         = '0;
         done_d        = 1'b0;
         overflow_d    = 1'b0;
         timeout_err_d = 1'b0;
      end

      unique case (state)
         S_ACCUM: begin
            if (accept_c) begin
               acc_d      = sat_c;
               idx_d      = idx + IDX_W'(1);
               load_mem_d = 1'b1;
               location_d = ADDR_W'(idx);
               mem_data_d = sat_c;
               if (carry_c) begin
                  overflow_d = 1'b1;
               end
            end
         end
         S_FLUSH: begin
            // extra strobe so the generator commits the last entry
            load_mem_d = 1'b1;
            location_d = ADDR_W'(LAST_IDX);
            mem_data_d = acc;
         end
         S_WAIT_DONE: begin
            cnt_d = cnt + CNT_W'(1);
            if (state_nx == S_DONE) begin
               done_d = 1'b1;
            end
            if (state_nx == S_ERROR) begin
               timeout_err_d = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // datapath and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc         <= '0;
         idx         <= '0;
         cnt         <= '0;
         pdf_ready   <= 1'b0;
         load_mem    <= 1'b0;
         location    <= '0;
         mem_data    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         acc         <= acc_d;
         idx         <= idx_d;
         cnt         <= cnt_d;
         pdf_ready   <= pdf_ready_d;
         load_mem    <= load_mem_d;
         location    <= location_d;
         mem_data    <= mem_data_d;
         busy        <= busy_d;
         done        <= done_d;
         overflow    <= overflow_d;
         timeout_err <= timeout_err_d;
      end
   end

endmodule

// File: tb/tb_noise_cdf_loader.sv
// ---------------------------------------------------------------------------
// tb_noise_cdf_loader
//   Randomized bench for noise_cdf_loader. Expected CDF values come from a
//   wide running total clamped to full scale; observed strobes are collected
//   by a negedge monitor and compared entry by entry after each load.
// ---------------------------------------------------------------------------
module tb_noise_cdf_loader;

   localparam int unsigned DEPTH   = 128;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rstn = 1'b1;
   logic              start = 1'b0;
   logic              pdf_valid = 1'b0;
   logic [DATA_W-1:0] pdf_data = '0;
   logic              done_wait_in = 1'b0;
   logic              pdf_ready;
   logic              load_mem;
   logic [ADDR_W-1:0] location;
   logic [DATA_W-1:0] mem_data;
   logic              busy;
   logic              done;
   logic              overflow;
   logic              timeout_err;

   noise_cdf_loader #(
      .DEPTH   (DEPTH),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .start        (start),
      .pdf_valid    (pdf_valid),
      .pdf_ready    (pdf_ready),
      .pdf_data     (pdf_data),
      .load_mem     (load_mem),
      .location     (location),
      .mem_data     (mem_data),
      .done_wait_in (done_wait_in),
      .busy         (busy),
      .done         (done),
      .overflow     (overflow),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                      input logic [DATA_W-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // reference model
   logic [DATA_W-1:0] tbl     [DEPTH];
   logic [DATA_W-1:0] exp_cdf [DEPTH];
   logic              exp_ovf;

   task automatic build_model();
      logic [DATA_W+7:0] total;
      logic [DATA_W+7:0] full;
      total = '0;
      full  = (DATA_W+8)'({DATA_W{1'b1}});
      for (int k = 0; k < int'(DEPTH); k++) begin
         total = total + (DATA_W+8)'(tbl[k]);
         exp_cdf[k] = (total > full) ? {DATA_W{1'b1}} : total[DATA_W-1:0];
      end
      exp_ovf = (total > full);
   endtask

   task automatic fill_uniform();
      for (int k = 0; k < int'(DEPTH); k++) tbl[k] = 64'h0200_0000_0000_0000;
   endtask

   task automatic fill_rand(input bit full_range);
      for (int k = 0; k < int'(DEPTH); k++) begin
         if (full_range) tbl[k] = {$urandom, $urandom};
         else            tbl[k] = {8'h00, 24'($urandom), $urandom};
      end
   endtask

   task automatic fill_sat();
      fill_rand(1'b0);
      tbl[0] = 64'hFFFF_FFFF_FFFF_FFF0;
      tbl[1] = 64'h0000_0000_0000_0020;
   endtask

   // strobe monitor
   typedef struct {
      logic [ADDR_W-1:0] loc;
      logic [DATA_W-1:0] dat;
   } strobe_t;

   strobe_t obs_q[$];
   bit      mon_en     = 1'b0;
   int      n_acc      = 0;
   bit      prev_acc   = 1'b0;
   bit      flush_next = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("load_mem_timing", DATA_W'(load_mem), DATA_W'(prev_acc || flush_next));
         if (load_mem) obs_q.push_back('{location, mem_data});
         flush_next = prev_acc && (n_acc == int'(DEPTH));
         prev_acc   = pdf_valid && pdf_ready;
         if (prev_acc) n_acc++;
      end
   end

   task automatic mon_clear();
      obs_q.delete();
      n_acc      = 0;
      prev_acc   = 1'b0;
      flush_next = 1'b0;
      mon_en     = 1'b1;
   endtask

   task automatic check_reset_outputs();
      chk("rst_pdf_ready",   DATA_W'(pdf_ready),   '0);
      chk("rst_load_mem",    DATA_W'(load_mem),    '0);
      chk("rst_location",    DATA_W'(location),    '0);
      chk("rst_mem_data",    mem_data,             '0);
      chk("rst_busy",        DATA_W'(busy),        '0);
      chk("rst_done",        DATA_W'(done),        '0);
      chk("rst_overflow",    DATA_W'(overflow),    '0);
      chk("rst_timeout_err", DATA_W'(timeout_err), '0);
   endtask

   // mode: 0 valid held high, 1 valid toggling 1-0-1, 2 random valid gaps
   task automatic run_load(input int mode, input bit mid_start, input int stop_at,
                           input bit expect_timeout);
      int idx;
      int cyc;
      int wait_cyc;
      bit acc;
      bit mid_done;
      int exp_loc;
      idx = 0; cyc = 0; mid_done = 1'b0;
      build_model();
      mon_clear();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start",      DATA_W'(busy),        DATA_W'(1));
      chk("ready_after_start",     DATA_W'(pdf_ready),   DATA_W'(1));
      chk("done_cleared",          DATA_W'(done),        '0);
      chk("overflow_cleared",      DATA_W'(overflow),    '0);
      chk("timeout_err_cleared",   DATA_W'(timeout_err), '0);

      while (idx < stop_at && cyc < 2000) begin
         case (mode)
            0:       pdf_valid = 1'b1;
            1:       pdf_valid = (cyc % 2 == 0);
            default: pdf_valid = ($urandom_range(0, 3) != 0);
         endcase
         pdf_data     = tbl[idx];
         done_wait_in = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (mid_start && !mid_done && idx == 10) begin
            start    = 1'b1;
            mid_done = 1'b1;
         end
         @(negedge clk);
         acc = pdf_valid && pdf_ready;
         @(posedge clk); #1;
         start = 1'b0;
         if (acc) idx++;
         cyc++;
      end
      done_wait_in = 1'b0;
      chk("feed_words", DATA_W'(idx), DATA_W'(stop_at));
      if (stop_at < int'(DEPTH)) begin
         pdf_valid = 1'b0;
         return;
      end

      // offer a surplus word; it must not be accepted
      pdf_valid = 1'b1;
      pdf_data  = {$urandom, $urandom};
      wait_cyc  = 0;
      while (obs_q.size() < int'(DEPTH) + 1 && wait_cyc < 20) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      chk("flush_strobe_seen", DATA_W'(obs_q.size()), DATA_W'(DEPTH + 1));
      chk("ready_low_after_last", DATA_W'(pdf_ready), '0);
      chk("busy_while_waiting",   DATA_W'(busy),      DATA_W'(1));

      if (expect_timeout) begin
         // count cycles from the final strobe until timeout_err shows
         wait_cyc = 1;
         while (!timeout_err && wait_cyc < 64) begin
            @(posedge clk); #1;
            wait_cyc++;
         end
         chk("timeout_latency", DATA_W'(wait_cyc), DATA_W'(TIMEOUT));
         chk("timeout_err_set",  DATA_W'(timeout_err), DATA_W'(1));
         chk("timeout_busy",     DATA_W'(busy),        '0);
         chk("timeout_done",     DATA_W'(done),        '0);
      end else begin
         repeat (2) @(posedge clk);
         #1 done_wait_in = 1'b1;
         @(posedge clk); #1;
         done_wait_in = 1'b0;
         chk("done_set",         DATA_W'(done),        DATA_W'(1));
         chk("done_busy",        DATA_W'(busy),        '0);
         chk("done_timeout_err", DATA_W'(timeout_err), '0);
      end
      pdf_valid = 1'b0;
      @(posedge clk); #1;
      mon_en = 1'b0;

      chk("overflow_flag",  DATA_W'(overflow),     DATA_W'(exp_ovf));
      chk("accepted_words", DATA_W'(n_acc),        DATA_W'(DEPTH));
      chk("strobe_count",   DATA_W'(obs_q.size()), DATA_W'(DEPTH + 1));
      chk("location_hold",  DATA_W'(location),     DATA_W'(DEPTH - 1));
      chk("mem_data_hold",  mem_data,              exp_cdf[DEPTH-1]);
      chk("load_mem_idle",  DATA_W'(load_mem),     '0);
      for (int k = 0; k < obs_q.size() && k <= int'(DEPTH); k++) begin
         exp_loc = (k < int'(DEPTH)) ? k : int'(DEPTH) - 1;
         chk($sformatf("location[%0d]", k), DATA_W'(obs_q[k].loc), DATA_W'(exp_loc));
         chk($sformatf("mem_data[%0d]", k), obs_q[k].dat, exp_cdf[exp_loc]);
      end
   endtask

   initial begin
      #3 rstn = 1'b0;
      #1 check_reset_outputs();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      fill_uniform();    run_load(0, 1'b0, DEPTH, 1'b0);
      fill_uniform();    run_load(1, 1'b0, DEPTH, 1'b0);
      fill_sat();        run_load(2, 1'b0, DEPTH, 1'b0);
      fill_rand(1'b0);   run_load(2, 1'b0, DEPTH, 1'b1);
      fill_rand(1'b0);   run_load(0, 1'b1, DEPTH, 1'b0);

      // reset in the middle of a load
      fill_rand(1'b0);   run_load(2, 1'b0, 40, 1'b0);
      mon_en = 1'b0;
      rstn   = 1'b0;
      #1 check_reset_outputs();
      @(posedge clk);
      #1 rstn = 1'b1;

      fill_rand(1'b0);   run_load(2, 1'b0, DEPTH, 1'b0);
      fill_rand(1'b1);   run_load(0, 1'b0, DEPTH, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
      $fatal(1);
   end

endmodule

// File: doc/noise_cdf_loader.md
Name: noise_cdf_loader

Overview:
- Upstream feeder for the 128-level noise generator: accepts a 128-entry probability mass table (PMF, 64-bit fixed-point, full scale = 2^64) over a valid/ready stream.
- Accumulates the entries into a saturating cumulative distribution (CDF).
- Drives the generator's table-load interface (load_mem / location / mem_data), then waits for the generator's done_wait before reporting completion.
- Sits between the host/ROM table source and the noise generator.

Parameters:
DEPTH, 128, number of table entries (levels)
DATA_W, 64, width of PMF/CDF words
ADDR_W, 8, width of location output
TIMEOUT, 1024, max cycles to wait for done_wait_in after the final strobe

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a load when idle
pdf_valid  input  1  PMF word present
pdf_ready  output  1  loader accepts PMF word this cycle
pdf_data  input  DATA_W  PMF word, unsigned
load_mem  output  1  table write strobe to the noise generator
location  output  ADDR_W  table index for the current strobe
mem_data  output  DATA_W  CDF value for location
done_wait_in  input  1  generator reports its table is complete
busy  output  1  load in progress
done  output  1  level-high after a successful load, until the next start
overflow  output  1  sticky; the cumulative sum saturated during the current load
timeout_err  output  1  sticky; done_wait_in not seen within TIMEOUT cycles

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rstn.
- Reset values: all outputs 0; state IDLE; accumulator 0; index 0.
- States: IDLE, ACCUM, FLUSH, WAIT_DONE, DONE, ERROR.
- IDLE/DONE/ERROR + start=1 -> ACCUM. Entering ACCUM clears the accumulator, index, done, overflow and timeout_err. busy=1 in ACCUM, FLUSH and WAIT_DONE.
- start while busy is ignored.
- ACCUM:
  - pdf_ready=1.
  - A word is accepted when pdf_valid && pdf_ready.
  - On acceptance, sum = acc + pdf_data computed at DATA_W+1 bits. If the carry is set, the result saturates to all-ones and overflow is set.
  - acc is updated with the saturated result.
- Output timing:
  - In the cycle after acceptance: load_mem=1, location=index (zero-extended), mem_data=new acc. Then index increments.
  - load_mem is 0 in every cycle with no acceptance. Stalls on pdf_valid insert gaps; no data is lost.
- After the acceptance with index==DEPTH-1:
  - pdf_ready drops the same cycle.
  - Next state is FLUSH.
- FLUSH (one cycle):
  - Reissues load_mem=1 with location=DEPTH-1 and the same mem_data.
  - Total strobes per load = DEPTH+1 exactly. The generator commits its writes with a one-cycle lag and needs that count to assert done_wait.
  - Next state is WAIT_DONE.
- WAIT_DONE:
  - pdf_ready=0, load_mem=0.
  - A cycle counter runs. done_wait_in=1 -> DONE (done=1, busy=0).
  - If the counter reaches TIMEOUT first -> ERROR (timeout_err=1, busy=0, done=0).
- Once saturated, the accumulator stays all-ones for the remaining entries. All later mem_data equal all-ones.
- location/mem_data hold their last values when load_mem=0.
- Reset mid-load: returns immediately to IDLE with all outputs 0. The partial table is abandoned; the next start performs a full reload.
- done_wait_in is ignored outside WAIT_DONE.
- A pdf_valid arriving after the final word is not accepted (pdf_ready=0).

Test Plan:
- Uniform load: start, 128 words of 2^57 with pdf_valid held high -> 129 strobes; location 0..127 then 127 again; mem_data[k]=(k+1)*2^57; mem_data[127]=2^64 saturates to all-ones and sets overflow. done_wait_in pulsed 3 cycles after FLUSH -> done=1, busy=0.
- Backpressure gaps: same table with pdf_valid toggling 1-0-1 -> strobes appear only the cycle after each acceptance; values identical to the first test; total strobes still 129.
- Saturation: entry 0 = 0xFFFF_FFFF_FFFF_FFF0, entry 1 = 0x20 -> mem_data for location 1 = all-ones, overflow=1; all later entries all-ones.
- Timeout: TIMEOUT=16, done_wait_in never asserted -> timeout_err=1 exactly 16 cycles after FLUSH; busy=0, done=0. A subsequent start clears timeout_err.
- Reset mid-load: deassert rstn after 40 accepted words -> all outputs 0 asynchronously. A new start reloads from location 0 with the accumulator at 0.
- Start while busy: pulse start at word 10 -> ignored; sequence continues uninterrupted to 129 strobes.
